dh_handshake_ctrl: RTL and testbench
====================================

Name: dh_handshake_ctrl

Overview:
Parametrised successor to the key-exchange acceptance controller. It sequences NUM_CHECKS ordered verification stages and applies a per-stage timeout and a bounded retry policy. It reports the outcome as an ASCII status word ("ACCEPT"/"REJECT") plus strobes. It sits between the modular-exponentiation/compare datapath, which drives per-stage ok/fail, and the host/status interface.

Parameters:
NUM_CHECKS, 2, number of ordered verification stages (>=1)
TIMEOUT_CYCLES, 256, max cycles spent in one stage before forced fail; 0 disables timeout
MAX_RETRIES, 3, restarts from stage 0 allowed after a fail before REJECT (0 = no retry)
MSG_W, 48, status word width (6 ASCII chars)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  begin sequence (sampled in IDLE only)
check_ok  in  NUM_CHECKS  bit k = stage k passed (level; only bit of current stage is used)
check_fail  in  1  current stage failed (level)
key_hold  in  1  keep ACCEPT asserted while high
rej_ack  in  1  host acknowledges REJECT
abort  in  1  synchronous abort to IDLE from any state
status_msg  out  MSG_W  ASCII status word
busy  out  1  high in CHECK
done  out  1  1-cycle pulse on entry to ACCEPT or REJECT
stage  out  max(1,$clog2(NUM_CHECKS))  current stage index
retry_cnt  out  $clog2(MAX_RETRIES+1)  retries consumed in this sequence

Behaviour:
- Reset (rst=0, async): state=IDLE, stage=0, retry_cnt=0, timer=0, done=0, status_msg=0, busy=0.
- States: IDLE, CHECK, ACCEPT, REJECT. Outputs are Moore-decoded from registered state/counters except done, which is a registered pulse.
- IDLE: start=1 -> CHECK, stage=0, retry_cnt=0, timer=0. Otherwise hold.
- CHECK, per-cycle priority: abort > check_fail > timeout > check_ok[stage].
  - abort -> IDLE; counters cleared.
  - fail event (check_fail, or timer==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0): if retry_cnt<MAX_RETRIES -> stay CHECK, stage=0, timer=0, retry_cnt+1; else -> REJECT.
  - check_ok[stage]=1: if stage==NUM_CHECKS-1 -> ACCEPT; else stage+1, timer=0.
  - Otherwise timer+1 (saturates; never wraps).
  - Simultaneous check_ok and check_fail: fail wins. Ok on the final timeout cycle: timeout wins.
- ACCEPT: status_msg=0x414343455054 ("ACCEPT"). key_hold=1 -> stay; key_hold=0 -> IDLE. abort -> IDLE.
- REJECT: status_msg=0x52454A454354 ("REJECT"). rej_ack=1 or abort=1 -> IDLE.
- status_msg=0 in IDLE and CHECK; busy=1 only in CHECK.
- done=1 for exactly the first cycle in ACCEPT/REJECT, i.e. 1 cycle after the transition edge.
- stage and retry_cnt keep their values in ACCEPT/REJECT for host readout. They clear on return to IDLE.
- start is ignored outside IDLE. A back-to-back start in the IDLE cycle after ACCEPT/REJECT is legal.
- Minimum latency start->ACCEPT: 1+NUM_CHECKS cycles when every check_ok is already high.
- Reset mid-sequence: immediate return to reset values. No partial status is retained.
- If MSG_W>48, status_msg is zero-extended in the MSBs. MSG_W<48 is illegal (elaboration assertion).

Decomposition:
- Package dh_ctrl_pkg: state enum (IDLE, CHECK, ACCEPT, REJECT), MSG_ACCEPT=48'h414343455054, MSG_REJECT=48'h52454A454354, width helper functions.
- One sub-module, dh_stage_timer: a saturating cycle counter with clear, enable, and a TIMEOUT_CYCLES compare that outputs the expired flag. It is instantiated once.

Test Plan:
- Reset then start with check_ok=2'b11 held -> ACCEPT entered 3 cycles after start; done pulses 1 cycle; status_msg=0x414343455054; key_hold=0 -> IDLE next cycle, status_msg=0.
- NUM_CHECKS=2: check_fail pulsed in stage 1 four times -> retry_cnt 1,2,3, then REJECT with status_msg=0x52454A454354 and retry_cnt=3; rej_ack -> IDLE.
- TIMEOUT_CYCLES=8, check_ok never set -> retry after 8 cycles in the stage, 4 timeouts total -> REJECT at cycle 32 after CHECK entry.
- check_ok[0] and check_fail both high in the same cycle -> treated as fail: stage stays 0, retry_cnt=1.
- abort during CHECK at stage 1 and during ACCEPT -> IDLE next cycle, all outputs 0, no done pulse.
- rst asserted asynchronously mid-CHECK -> outputs 0 immediately. NUM_CHECKS=4 regression: stage steps 0..3, and a start pulse while busy is ignored.

Source files
------------

// File: rtl/dh_ctrl_pkg.sv
// Shared types and constants for the key-exchange acceptance controller.
// The status words are ASCII "ACCEPT" and "REJECT", MSB-first.
package dh_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ACCEPT = 2'd2,
    REJECT = 2'd3
  } dh_state_e;

  localparam int unsigned MSG_BASE_W = 48;
  localparam logic [47:0] MSG_ACCEPT = 48'h414343455054;
  localparam logic [47:0] MSG_REJECT = 48'h52454A454354;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned stage_w(input int unsigned num_checks);
    return cnt_w(num_checks);
  endfunction

  function automatic int unsigned retry_w(input int unsigned max_retries);
    return cnt_w(max_retries + 1);
  endfunction

endpackage

// File: rtl/dh_stage_timer.sv
// Per-stage cycle counter: saturating, synchronous clear, and an expired flag
// raised on the last permitted cycle of a stage (never raised when timeout is 0).
module dh_stage_timer
  import dh_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned TW = cnt_w(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {TW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      assign expired_o = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/dh_handshake_ctrl.sv
// Sequences NUM_CHECKS ordered verification stages with per-stage timeout and
// bounded retry, then reports ACCEPT/REJECT as an ASCII status word plus strobes.
module dh_handshake_ctrl
  import dh_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CHECKS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned MSG_W          = 48,
  localparam int unsigned SW = stage_w(NUM_CHECKS),
  localparam int unsigned RW = retry_w(MAX_RETRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_CHECKS-1:0] check_ok,
  input  logic                  check_fail,
  input  logic                  key_hold,
  input  logic                  rej_ack,
  input  logic                  abort,
  output logic [MSG_W-1:0]      status_msg,
  output logic                  busy,
  output logic                  done,
  output logic [SW-1:0]         stage,
  output logic [RW-1:0]         retry_cnt,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_CHECK  = CHECK;
  localparam logic [1:0] S_ACCEPT = ACCEPT;
  localparam logic [1:0] S_REJECT = REJECT;

  generate
    if (MSG_W < MSG_BASE_W) begin : g_bad_msg_w
      $error("dh_handshake_ctrl: MSG_W must be at least 48");
    end
    if (NUM_CHECKS < 1) begin : g_bad_num_checks
      $error("dh_handshake_ctrl: NUM_CHECKS must be at least 1");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          done_q, done_d;
  logic          tmr_clr, tmr_en, tmr_expired;
  logic          fail_ev, ok_cur, last_stage;

  assign fail_ev    = check_fail || tmr_expired;
  assign ok_cur     = check_ok[stage_q];
  assign last_stage = (stage_q == SW'(NUM_CHECKS - 1));

  // Priority inside CHECK: abort, then fail (explicit or timeout), then stage ok.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    retry_d = retry_q;
    tmr_clr = (state_q != S_CHECK);
    tmr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CHECK;
          stage_d = '0;
          retry_d = '0;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          stage_d = '0;
          retry_d = '0;
          tmr_clr = 1'b1;
        end else if (fail_ev) begin
          tmr_clr = 1'b1;
          if (retry_q < RW'(MAX_RETRIES)) begin
            stage_d = '0;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = S_REJECT;
          end
        end else if (ok_cur) begin
          tmr_clr = 1'b1;
          if (last_stage) begin
            state_d = S_ACCEPT;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_ACCEPT: begin
        if (abort || !key_hold) begin
          state_d = S_IDLE;
          stage_d = '0;
          retry_d = '0;
        end
      end
      default: begin
        if (abort || rej_ack) begin
          state_d = S_IDLE;
          stage_d = '0;
          retry_d = '0;
        end
      end
    endcase
  end

  assign done_d = (state_q == S_CHECK) &&
                  ((state_d == S_ACCEPT) || (state_d == S_REJECT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      retry_q <= retry_d;
      done_q  <= done_d;
    end
  end

  dh_stage_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    case (state_q)
      S_ACCEPT: status_msg = MSG_W'(MSG_ACCEPT);
      S_REJECT: status_msg = MSG_W'(MSG_REJECT);
      default:  status_msg = '0;
    endcase
  end

  assign busy      = (state_q == S_CHECK);
  assign done      = done_q;
  assign stage     = stage_q;
  assign retry_cnt = retry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dh_handshake_ctrl.sv
// Bench for dh_handshake_ctrl: a 2-stage instance with an 8-cycle timeout and
// a 4-stage instance with timeout disabled and a single retry.
module tb_dh_handshake_ctrl;

  localparam logic [47:0] ACC = 48'h414343455054;
  localparam logic [47:0] REJ = 48'h52454A454354;
  localparam int SB_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Instance A: NUM_CHECKS=2, TIMEOUT_CYCLES=8, MAX_RETRIES=3
  logic        start = 0, check_fail = 0, key_hold = 0, rej_ack = 0, abort = 0;
  logic [1:0]  check_ok = '0;
  logic [47:0] status_msg;
  logic        busy, done;
  logic [0:0]  stage;
  logic [1:0]  retry_cnt;
  logic [1:0]  dbg_state;

  // Instance B: NUM_CHECKS=4, TIMEOUT_CYCLES=0, MAX_RETRIES=1
  logic        start_b = 0, fail_b = 0, key_b = 0, ack_b = 0, abort_b = 0;
  logic [3:0]  ok_b = '0;
  logic [47:0] msg_b;
  logic        busy_b, done_b;
  logic [1:0]  stage_b;
  logic [0:0]  retry_b;
  logic [1:0]  dbg_b;

  int total = 0;
  int bad   = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] exp_b_q[$];

  dh_handshake_ctrl #(.NUM_CHECKS(2), .TIMEOUT_CYCLES(8), .MAX_RETRIES(3), .MSG_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .check_ok(check_ok), .check_fail(check_fail),
    .key_hold(key_hold), .rej_ack(rej_ack), .abort(abort), .status_msg(status_msg),
    .busy(busy), .done(done), .stage(stage), .retry_cnt(retry_cnt), .dbg_state(dbg_state)
  );

  dh_handshake_ctrl #(.NUM_CHECKS(4), .TIMEOUT_CYCLES(0), .MAX_RETRIES(1), .MSG_W(48)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .check_ok(ok_b), .check_fail(fail_b),
    .key_hold(key_b), .rej_ack(ack_b), .abort(abort_b), .status_msg(msg_b),
    .busy(busy_b), .done(done_b), .stage(stage_b), .retry_cnt(retry_b), .dbg_state(dbg_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [SB_W-1:0] pk(input logic [47:0] m, input int r, input int s);
    return (SB_W'(m) << 16) | (SB_W'(r) << 8) | SB_W'(s);
  endfunction

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (rst && done) begin
      logic [SB_W-1:0] e, got;
      total++;
      got = pk(status_msg, int'(retry_cnt), int'(stage));
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_a unexpected done got=%h exp=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL sb_a result got=%h exp=%h", got, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && done_b) begin
      logic [SB_W-1:0] e, got;
      total++;
      got = pk(msg_b, int'(retry_b), int'(stage_b));
      if (exp_b_q.size() == 0) begin
        bad++;
        $display("FAIL sb_b unexpected done got=%h exp=none", got);
      end else begin
        e = exp_b_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL sb_b result got=%h exp=%h", got, e);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    tick(2);
    total++;
    if ({status_msg, busy, done, stage, retry_cnt, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_a got=%h exp=0", {status_msg, busy, done, stage, retry_cnt, dbg_state});
    end
    total++;
    if ({msg_b, busy_b, done_b, stage_b, retry_b, dbg_b} !== '0) begin
      bad++;
      $display("FAIL reset_b got=%h exp=0", {msg_b, busy_b, done_b, stage_b, retry_b, dbg_b});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_accept;
    check_ok = 2'b11; key_hold = 1'b1; start = 1'b1;
    exp_q.push_back(pk(ACC, 0, 1));
    tick(); start = 1'b0;
    total++;
    if (busy !== 1'b1 || stage !== 1'b0) begin
      bad++; $display("FAIL accept_c1 busy=%b stage=%0d exp busy=1 stage=0", busy, stage);
    end
    tick();
    total++;
    if (busy !== 1'b1 || stage !== 1'b1) begin
      bad++; $display("FAIL accept_c2 busy=%b stage=%0d exp busy=1 stage=1", busy, stage);
    end
    tick();
    total++;
    if (done !== 1'b1 || status_msg !== ACC || busy !== 1'b0) begin
      bad++; $display("FAIL accept_c3 done=%b msg=%h busy=%b exp done=1 msg=%h busy=0", done, status_msg, busy, ACC);
    end
    tick();
    total++;
    if (done !== 1'b0 || status_msg !== ACC) begin
      bad++; $display("FAIL accept_hold done=%b msg=%h exp done=0 msg=%h", done, status_msg, ACC);
    end
    key_hold = 1'b0;
    tick();
    total++;
    if (status_msg !== 48'h0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL accept_release msg=%h state=%0d exp msg=0 state=0", status_msg, dbg_state);
    end
    check_ok = 2'b00;
  endtask

  task automatic test_retry;
    check_ok = 2'b00; start = 1'b1;
    exp_q.push_back(pk(REJ, 3, 1));
    tick(); start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      check_ok = 2'b01;
      tick();
      total++;
      if (stage !== 1'b1) begin
        bad++; $display("FAIL retry_stage1 r=%0d stage=%0d exp=1", r, stage);
      end
      check_ok = 2'b00; check_fail = 1'b1;
      tick();
      check_fail = 1'b0;
      total++;
      if (r < 3) begin
        if (stage !== 1'b0 || retry_cnt !== 2'(r + 1) || busy !== 1'b1) begin
          bad++; $display("FAIL retry_cnt r=%0d stage=%0d retry=%0d busy=%b exp stage=0 retry=%0d busy=1",
                          r, stage, retry_cnt, busy, r + 1);
        end
      end else if (dbg_state !== 2'd3 || status_msg !== REJ || retry_cnt !== 2'd3) begin
        bad++; $display("FAIL retry_reject state=%0d msg=%h retry=%0d exp state=3 msg=%h retry=3",
                        dbg_state, status_msg, retry_cnt, REJ);
      end
    end
    rej_ack = 1'b1;
    tick(); rej_ack = 1'b0;
    total++;
    if ({dbg_state, retry_cnt, stage, status_msg} !== '0) begin
      bad++; $display("FAIL rej_ack got=%h exp=0", {dbg_state, retry_cnt, stage, status_msg});
    end
  endtask

  task automatic test_timeout;
    check_ok = 2'b00; start = 1'b1;
    exp_q.push_back(pk(REJ, 3, 0));
    tick(); start = 1'b0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      total++;
      if (busy !== 1'b1 || retry_cnt !== 2'((cyc - 1) / 8)) begin
        bad++; $display("FAIL timeout_cyc%0d busy=%b retry=%0d exp busy=1 retry=%0d",
                        cyc, busy, retry_cnt, (cyc - 1) / 8);
      end
      tick();
    end
    total++;
    if (dbg_state !== 2'd3 || status_msg !== REJ) begin
      bad++; $display("FAIL timeout_reject state=%0d msg=%h exp state=3 msg=%h", dbg_state, status_msg, REJ);
    end
    rej_ack = 1'b1;
    tick(); rej_ack = 1'b0;
  endtask

  task automatic test_ok_fail_same;
    check_ok = 2'b00; start = 1'b1;
    tick(); start = 1'b0;
    check_ok = 2'b01; check_fail = 1'b1;
    tick();
    check_ok = 2'b00; check_fail = 1'b0;
    total++;
    if (stage !== 1'b0 || retry_cnt !== 2'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL ok_fail_same stage=%0d retry=%0d busy=%b exp stage=0 retry=1 busy=1",
                      stage, retry_cnt, busy);
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
  endtask

  task automatic test_abort;
    check_ok = 2'b01; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    total++;
    if (stage !== 1'b1) begin
      bad++; $display("FAIL abort_pre stage=%0d exp=1", stage);
    end
    check_ok = 2'b00; abort = 1'b1;
    tick(); abort = 1'b0;
    total++;
    if ({dbg_state, busy, done, stage, retry_cnt, status_msg} !== '0) begin
      bad++; $display("FAIL abort_check got=%h exp=0", {dbg_state, busy, done, stage, retry_cnt, status_msg});
    end
    check_ok = 2'b11; key_hold = 1'b1; start = 1'b1;
    exp_q.push_back(pk(ACC, 0, 1));
    tick(); start = 1'b0;
    tick(2);
    total++;
    if (dbg_state !== 2'd2) begin
      bad++; $display("FAIL abort_pre_accept state=%0d exp=2", dbg_state);
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
    total++;
    if ({dbg_state, busy, done, stage, retry_cnt, status_msg} !== '0) begin
      bad++; $display("FAIL abort_accept got=%h exp=0", {dbg_state, busy, done, stage, retry_cnt, status_msg});
    end
    key_hold = 1'b0; check_ok = 2'b00;
  endtask

  task automatic test_async_reset;
    check_ok = 2'b01; start = 1'b1;
    tick(); start = 1'b0; check_ok = 2'b00; check_fail = 1'b1;
    tick(); check_fail = 1'b0; check_ok = 2'b01;
    tick(); check_ok = 2'b00;
    total++;
    if (stage !== 1'b1 || retry_cnt !== 2'd1) begin
      bad++; $display("FAIL arst_pre stage=%0d retry=%0d exp stage=1 retry=1", stage, retry_cnt);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({dbg_state, busy, done, stage, retry_cnt, status_msg} !== '0) begin
      bad++; $display("FAIL arst_mid got=%h exp=0", {dbg_state, busy, done, stage, retry_cnt, status_msg});
    end
    tick(); rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    key_hold = 1'b0; check_ok = 2'b11; start = 1'b1;
    exp_q.push_back(pk(ACC, 0, 1));
    exp_q.push_back(pk(ACC, 0, 1));
    tick(2);
    total++;
    if (stage !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_no_restart stage=%0d busy=%b exp stage=1 busy=1", stage, busy);
    end
    tick();
    total++;
    if (status_msg !== ACC) begin
      bad++; $display("FAIL b2b_first msg=%h exp=%h", status_msg, ACC);
    end
    tick();
    total++;
    if (dbg_state !== 2'd0 || busy !== 1'b0 || status_msg !== 48'h0) begin
      bad++; $display("FAIL b2b_idle state=%0d busy=%b msg=%h exp 0", dbg_state, busy, status_msg);
    end
    tick();
    total++;
    if (busy !== 1'b1 || stage !== 1'b0) begin
      bad++; $display("FAIL b2b_restart busy=%b stage=%0d exp busy=1 stage=0", busy, stage);
    end
    tick(2);
    start = 1'b0;
    total++;
    if (dbg_state !== 2'd2) begin
      bad++; $display("FAIL b2b_second state=%0d exp=2", dbg_state);
    end
    tick();
    check_ok = 2'b00;
  endtask

  task automatic test_four_stage;
    ok_b = 4'b0000; start_b = 1'b1;
    exp_b_q.push_back(pk(ACC, 0, 3));
    tick(); start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = (k == 0) ? 300 : int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) begin
        start_b = 1'($urandom_range(0, 1));
        tick();
        total++;
        if (stage_b !== 2'(k) || busy_b !== 1'b1 || retry_b !== 1'b0) begin
          bad++; $display("FAIL four_wait k=%0d i=%0d stage=%0d busy=%b retry=%0d exp stage=%0d busy=1 retry=0",
                          k, i, stage_b, busy_b, retry_b, k);
        end
      end
      start_b = 1'b0;
      ok_b = 4'(1 << k);
      tick();
      ok_b = 4'b0000;
      total++;
      if (k < 3) begin
        if (stage_b !== 2'(k + 1) || busy_b !== 1'b1) begin
          bad++; $display("FAIL four_step k=%0d stage=%0d busy=%b exp stage=%0d busy=1", k, stage_b, busy_b, k + 1);
        end
      end else if (dbg_b !== 2'd2 || msg_b !== ACC) begin
        bad++; $display("FAIL four_accept state=%0d msg=%h exp state=2 msg=%h", dbg_b, msg_b, ACC);
      end
    end
    tick();
    total++;
    if (dbg_b !== 2'd0 || msg_b !== 48'h0) begin
      bad++; $display("FAIL four_idle state=%0d msg=%h exp state=0 msg=0", dbg_b, msg_b);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_retry();
    test_timeout();
    test_ok_fail_same();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_four_stage();
    tick(2);
    total++;
    if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
      bad++; $display("FAIL sb_drain left_a=%0d left_b=%0d exp=0", exp_q.size(), exp_b_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
